// File: rtl/spdif_rx_dma_buffer.sv
// Receive-side sample buffer: packs decoded SPDIF subframes into wide words,
// stores them in a circular RAM and exposes that RAM on a DMA slave port.
//
// Handshake: a subframe transfers on a posedge where smp_valid_i and
// smp_ready_o are both high. smp_ready_o depends only on enable_i and
// ptr_clr_i, never on smp_valid_i. A producer that raises valid holds
// smp_dat_i stable until it sees the transfer.
module spdif_rx_dma_buffer #(
  parameter int DMA_DWIDTH = 128,
  parameter int DMA_AWIDTH = 7,
  parameter int SMP_WIDTH  = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  ptr_clr_i,
  input  logic [SMP_WIDTH-1:0]  smp_dat_i,
  input  logic                  smp_valid_i,
  output logic                  smp_ready_o,
  input  logic                  dma_en_i,
  input  logic                  dma_we_i,
  input  logic [DMA_AWIDTH-1:0] dma_adr_i,
  input  logic [DMA_DWIDTH-1:0] dma_dat_i,
  output logic [DMA_DWIDTH-1:0] dma_dat_o,
  output logic [DMA_AWIDTH-1:0] wr_ptr_o,
  output logic                  half_irq_o,
  output logic                  wrap_irq_o,
  output logic                  collide_o
);

  // At least two lanes per word are assumed: the shadow register holds all
  // lanes except the last, which is taken straight from the input.
  localparam int LANES = DMA_DWIDTH / SMP_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SHW   = DMA_DWIDTH - SMP_WIDTH;
  localparam int DEPTH = 1 << DMA_AWIDTH;

  localparam logic [LW-1:0]         LANE_LAST = LW'(LANES - 1);
  localparam logic [DMA_AWIDTH-1:0] HALF_LAST = DMA_AWIDTH'((DEPTH / 2) - 1);
  localparam logic [DMA_AWIDTH-1:0] RING_LAST = '1;

  logic [DMA_DWIDTH-1:0] mem [DEPTH];
  logic [LW-1:0]         lane_cnt;
  logic [SHW-1:0]        shadow;
  logic [DMA_AWIDTH-1:0] wr_ptr;
  logic                  smp_fire;
  logic                  pk_we;
  logic                  collision;
  logic [DMA_DWIDTH-1:0] pk_word;

  assign smp_ready_o = enable_i & ~ptr_clr_i;
  assign smp_fire    = smp_valid_i & smp_ready_o;
  // The last lane completes a word on the same edge it is accepted.
  assign pk_we       = smp_fire & (lane_cnt == LANE_LAST);
  assign pk_word     = {smp_dat_i, shadow};
  assign collision   = pk_we & dma_we_i & (dma_adr_i == wr_ptr);
  assign wr_ptr_o    = wr_ptr;

  // Lane counter, shadow lanes and ring write pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_cnt <= '0;
      shadow   <= '0;
      wr_ptr   <= '0;
    end else if (ptr_clr_i) begin
      lane_cnt <= '0;
      wr_ptr   <= '0;
    end else if (!enable_i) begin
      // Partial word is discarded; stale shadow lanes get overwritten later.
      lane_cnt <= '0;
    end else if (smp_fire) begin
      if (lane_cnt == LANE_LAST) begin
        lane_cnt <= '0;
        wr_ptr   <= wr_ptr + DMA_AWIDTH'(1);
      end else begin
        lane_cnt <= lane_cnt + LW'(1);
        for (int i = 0; i < LANES - 1; i++) begin
          if (lane_cnt == LW'(i)) shadow[i*SMP_WIDTH +: SMP_WIDTH] <= smp_dat_i;
        end
      end
    end
  end

  // Half/wrap pulses for ping-pong draining and the sticky collision flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      half_irq_o <= 1'b0;
      wrap_irq_o <= 1'b0;
      collide_o  <= 1'b0;
    end else begin
      half_irq_o <= pk_we & (wr_ptr == HALF_LAST);
      wrap_irq_o <= pk_we & (wr_ptr == RING_LAST);
      if (ptr_clr_i)      collide_o <= 1'b0;
      else if (collision) collide_o <= 1'b1;
    end
  end

  // DMA read port: registered, read-before-write against either writer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         dma_dat_o <= '0;
    else if (dma_en_i) dma_dat_o <= mem[dma_adr_i];
  end

  // RAM writes: packer port always wins; a colliding DMA write is dropped.
  always_ff @(posedge clk_i) begin
    if (dma_we_i && !collision) mem[dma_adr_i] <= dma_dat_i;
    if (pk_we)                  mem[wr_ptr]    <= pk_word;
  end

endmodule
